// File: rtl/fpu_params_pkg.sv
// Shared FPU width defaults used by the mantissa datapath blocks.
package fpu_params_pkg;
  localparam int MAN_WIDTH       = 24;
  localparam int EXPONENT_LENGTH = 8;
  localparam int FRACTION_LENGTH = 23;
  localparam int CLA_BLOCK_WIDTH = 4;
endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group: per-bit carries plus group generate/propagate.
// Carries are built as flat sum-of-products terms rather than a ripple.
module cla_group #(
  parameter int BLOCK_WIDTH = 4
) (
  input  logic [BLOCK_WIDTH-1:0] a_i,
  input  logic [BLOCK_WIDTH-1:0] b_i,
  input  logic                   cin_i,
  output logic                   g_o,
  output logic                   p_o,
  output logic [BLOCK_WIDTH-1:0] c_o
);
  logic [BLOCK_WIDTH-1:0] gen, prop;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;
  assign p_o  = &prop;

  // Carry into each bit: cin propagated through all lower bits, or any lower generate propagated up.
  always_comb begin
    logic term, acc;
    c_o = '0;
    for (int i = 0; i < BLOCK_WIDTH; i++) begin
      term = cin_i;
      for (int m = 0; m < i; m++) term = term & prop[m];
      acc = term;
      for (int k = 0; k < i; k++) begin
        term = gen[k];
        for (int m = k + 1; m < i; m++) term = term & prop[m];
        acc = acc | term;
      end
      c_o[i] = acc;
    end
  end

  // Group generate is kept apart from the carry block so it never depends on cin.
  always_comb begin
    logic gterm, gacc;
    gacc = 1'b0;
    for (int k = 0; k < BLOCK_WIDTH; k++) begin
      gterm = gen[k];
      for (int m = k + 1; m < BLOCK_WIDTH; m++) gterm = gterm & prop[m];
      gacc = gacc | gterm;
    end
    g_o = gacc;
  end
endmodule

// File: rtl/mantissa_addsub_pipe.sv
// Sign-magnitude mantissa add/subtract with two-level carry lookahead and an
// elastic register pipeline (each stage loads when empty or when draining).
module mantissa_addsub_pipe #(
  parameter int MAN_WIDTH   = fpu_params_pkg::MAN_WIDTH,
  parameter int BLOCK_WIDTH = fpu_params_pkg::CLA_BLOCK_WIDTH,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN_WIDTH-1:0] man_x,
  input  logic [MAN_WIDTH-1:0] man_y,
  input  logic                 sign_x,
  input  logic                 sign_y,
  input  logic                 add_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAN_WIDTH-1:0] result,
  output logic                 result_sign,
  output logic                 cout,
  output logic                 zero
);
  localparam int NG = MAN_WIDTH / BLOCK_WIDTH;

  if ((MAN_WIDTH % BLOCK_WIDTH) != 0) begin : g_bad_width
    $fatal(1, "MAN_WIDTH must be a multiple of BLOCK_WIDTH");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $fatal(1, "PIPE_STAGES must be in 1..4");
  end

  typedef struct packed {
    logic [MAN_WIDTH-1:0] mag;
    logic                 sign;
    logic                 cout;
    logic                 zero;
  } res_t;

  // Adder 0 forms x+y or x-y; adder 1 forms y-x for the x<y correction.
  logic [1:0][MAN_WIDTH-1:0] add_a, add_b, add_s;
  logic [1:0]                add_cin, add_co;
  logic                      eff_sub;

  assign eff_sub  = add_sub ^ sign_x ^ sign_y;
  assign add_a[0] = man_x;
  assign add_b[0] = eff_sub ? ~man_y : man_y;
  assign add_cin[0] = eff_sub;
  assign add_a[1] = man_y;
  assign add_b[1] = ~man_x;
  assign add_cin[1] = 1'b1;

  for (genvar k = 0; k < 2; k++) begin : g_add
    logic [NG-1:0]        grp_g, grp_p;
    logic [NG:0]          grp_c;
    logic [MAN_WIDTH-1:0] bit_c;

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_grp (
        .a_i  (add_a[k][j*BLOCK_WIDTH +: BLOCK_WIDTH]),
        .b_i  (add_b[k][j*BLOCK_WIDTH +: BLOCK_WIDTH]),
        .cin_i(grp_c[j]),
        .g_o  (grp_g[j]),
        .p_o  (grp_p[j]),
        .c_o  (bit_c[j*BLOCK_WIDTH +: BLOCK_WIDTH])
      );
    end

    // Second lookahead level: every group carry-in is a flat function of group G/P and cin.
    always_comb begin
      logic t, acc;
      grp_c = '0;
      for (int j = 0; j <= NG; j++) begin
        t = add_cin[k];
        for (int m = 0; m < j; m++) t = t & grp_p[m];
        acc = t;
        for (int i = 0; i < j; i++) begin
          t = grp_g[i];
          for (int m = i + 1; m < j; m++) t = t & grp_p[m];
          acc = acc | t;
        end
        grp_c[j] = acc;
      end
    end

    assign add_s[k]  = add_a[k] ^ add_b[k] ^ bit_c;
    assign add_co[k] = grp_c[NG];
  end

  // Select magnitude/sign; a borrow from x-y means x<y so use y-x instead.
  res_t res_d;
  always_comb begin
    res_d = '0;
    if (!eff_sub) begin
      res_d.mag  = add_s[0];
      res_d.cout = add_co[0];
      res_d.sign = sign_x;
    end else if (add_co[0]) begin
      res_d.mag  = add_s[0];
      res_d.sign = sign_x;
    end else begin
      res_d.mag  = add_s[1];
      res_d.sign = sign_y ^ add_sub;
    end
    res_d.zero = (res_d.mag == '0);
    if (eff_sub && res_d.zero) res_d.sign = 1'b0;
  end

  // Pipeline state and per-stage load enables.
  logic [PIPE_STAGES:1] vld_q, ld, up_vld;
  res_t                 dat_q  [1:PIPE_STAGES];
  res_t                 up_dat [1:PIPE_STAGES];

  // A stage loads if it or any stage below it is empty, or the output drains.
  always_comb begin
    logic acc;
    acc = out_ready;
    ld  = '0;
    for (int s = PIPE_STAGES; s >= 1; s--) begin
      acc   = acc | ~vld_q[s];
      ld[s] = acc;
    end
  end

  // Upstream source of each stage: the arithmetic for stage 1, the previous stage otherwise.
  always_comb begin
    up_vld[1] = in_valid;
    up_dat[1] = res_d;
    for (int s = 2; s <= PIPE_STAGES; s++) begin
      up_vld[s] = vld_q[s-1];
      up_dat[s] = dat_q[s-1];
    end
  end

  // Advance the pipeline; data only captured alongside a valid so bubbles never overwrite.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 1; s <= PIPE_STAGES; s++) begin
        vld_q[s] <= 1'b0;
        dat_q[s] <= '0;
      end
    end else begin
      for (int s = 1; s <= PIPE_STAGES; s++) begin
        if (ld[s]) begin
          vld_q[s] <= up_vld[s];
          if (up_vld[s]) dat_q[s] <= up_dat[s];
        end
      end
    end
  end

  assign in_ready    = rst_n & ld[1];
  assign out_valid   = vld_q[PIPE_STAGES];
  assign result      = dat_q[PIPE_STAGES].mag;
  assign result_sign = dat_q[PIPE_STAGES].sign;
  assign cout        = dat_q[PIPE_STAGES].cout;
  assign zero        = dat_q[PIPE_STAGES].zero;
endmodule
